// File: rtl/vga_frame_scanout.sv
// vga_frame_scanout: 160x120x3 framebuffer scanned out as 640x480 VGA
// with 4x4 pixel replication and a post-reset background clear.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-low
//   x, y         write coordinate (x 0-159, y 0-119)
//   colour       write colour {R,G,B}
//   writeEn      write strobe, one write per clk
//   busy         framebuffer clear in progress, writes ignored
//   pix_en       one-clk pulse per VGA pixel tick
//   vga_hs/vs    active-low syncs
//   vga_blank_n  high in the visible area
//   vga_r/g/b    colour bits expanded to 8'hFF / 8'h00
//   frame_start  pulse on the tick at h_cnt=0, v_cnt=0

module vga_frame_scanout #(
    parameter int         CLK_DIV   = 2,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       writeEn,
    output logic       busy,
    output logic       pix_en,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       frame_start
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [14:0] LAST_ADDR = 15'd19199;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN
    } state_t;

    state_t      state;
    logic [14:0] clr_addr;

    logic [DW-1:0] div;
    logic          run;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;

    logic        s1_hs;
    logic        s1_vs;
    logic        s1_vis;
    logic [2:0]  pix_rgb;

    logic [2:0]  mem [0:19199];
    logic [2:0]  rd_data;
    logic [14:0] rd_addr;
    logic [14:0] wr_addr;
    logic        user_we;
    logic        clearing;
    logic        ram_we;
    logic [14:0] ram_wa;
    logic [2:0]  ram_wd;

    // Clear FSM: walks every address once after reset, then hands
    // the write port to the user.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
        end else begin
            unique case (state)
                CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + 15'd1;
                    end
                end
                RUN: begin
                    state <= RUN;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= CLEAR;
                    clr_addr <= '0;
                    busy     <= 1'b1;
                end
            endcase
        end
    end

    // y*160 + x as (y<<7)+(y<<5)+x, kept at full 15-bit width.
    assign wr_addr = {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};

    assign user_we = writeEn && !busy
                   && (x < 8'd160) && (y < 7'd120);

    assign clearing = (state == CLEAR);
    assign ram_we   = clearing || user_we;
    assign ram_wa   = clearing ? clr_addr : wr_addr;
    assign ram_wd   = clearing ? BG_COLOUR : colour;

    // 4x4 replication: drop the two low bits of each counter.
    assign rd_addr = {v_cnt[9:2], 7'b0}
                   + {2'b0, v_cnt[9:2], 5'b0}
                   + {7'b0, h_cnt[9:2]};

    // Read is enabled only on ticks so the data stays with the
    // tick that addressed it; same-edge writes return old data.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_wa] <= ram_wd;
        end
        if (pix_en) begin
            rd_data <= mem[rd_addr];
        end
    end

    // run keeps pix_en low during reset even when CLK_DIV is 1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div <= '0;
            run <= 1'b0;
        end else begin
            run <= 1'b1;
            if (div == DIV_MAX) begin
                div <= '0;
            end else begin
                div <= div + DW'(1);
            end
        end
    end

    assign pix_en      = run && (div == DIV_MAX);
    assign frame_start = pix_en && (h_cnt == 10'd0) && (v_cnt == 10'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == 10'd799) begin
                h_cnt <= '0;
                if (v_cnt == 10'd524) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 10'd1;
                end
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Stage 1 runs alongside the RAM read; stage 2 drives the pins.
    // Sync flags are held active-high internally so a zeroed
    // pipeline means "not in sync".
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_hs       <= 1'b0;
            s1_vs       <= 1'b0;
            s1_vis      <= 1'b0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            pix_rgb     <= 3'b000;
        end else if (pix_en) begin
            s1_hs       <= (h_cnt >= 10'd656) && (h_cnt <= 10'd751);
            s1_vs       <= (v_cnt >= 10'd490) && (v_cnt <= 10'd491);
            s1_vis      <= (h_cnt < 10'd640) && (v_cnt < 10'd480);
            vga_hs      <= !s1_hs;
            vga_vs      <= !s1_vs;
            vga_blank_n <= s1_vis;
            pix_rgb     <= s1_vis ? rd_data : 3'b000;
        end
    end

    assign vga_r = {8{pix_rgb[2]}};
    assign vga_g = {8{pix_rgb[1]}};
    assign vga_b = {8{pix_rgb[0]}};

endmodule

// File: tb/tb_vga_frame_scanout.sv
// tb_vga_frame_scanout: tick-count reference model of the scan-out
// and framebuffer, compared against vga_frame_scanout every clk.

module tb_vga_frame_scanout;

    localparam int         DIV = 1;
    localparam logic [2:0] BG  = 3'b000;
    localparam int         FRAME = 800 * 525;

    logic       clk;
    logic       reset;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       writeEn;
    logic       busy;
    logic       pix_en;
    logic       vga_hs;
    logic       vga_vs;
    logic       vga_blank_n;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic       frame_start;

    vga_frame_scanout #(
        .CLK_DIV  (DIV),
        .BG_COLOUR(BG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .writeEn    (writeEn),
        .busy       (busy),
        .pix_en     (pix_en),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .vga_blank_n(vga_blank_n),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .frame_start(frame_start)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int epoch = 0;

    // model state
    bit         mv = 0;
    int         c;
    int         t;
    logic [2:0] mm [19200];
    logic       s_hs, s_vs, s_bl, s_valid;
    logic [2:0] s_rgb;
    int         s_h, s_v, s_f;
    logic       o_hs, o_vs, o_bl, o_valid;
    logic [2:0] o_rgb;
    int         o_h, o_v, o_f;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s: got %h want %h (t=%0d)",
                         nm, act, exp, t);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic rand_drive(input int ymin);
        writeEn = 1'($urandom_range(0, 1));
        x       = 8'($urandom_range(0, 175));
        y       = 7'($urandom_range(ymin, 127));
        colour  = 3'($urandom_range(0, 7));
    endtask

    task automatic put(input int px, input int py, input int pc);
        writeEn = 1'b1;
        x       = 8'(px);
        y       = 7'(py);
        colour  = 3'(pc);
        nxt();
        writeEn = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: tick k shows pixel (k%800, (k/800)%525); its
    // outputs appear two ticks later; RAM reads see pre-edge data.
    initial begin
        int h, v;
        logic vis;
        forever begin
            @(posedge clk);
            if (!reset) begin
                mv = 1;
                c  = 0;
                t  = 0;
                for (int i = 0; i < 19200; i++) mm[i] = BG;
                s_hs = 1; s_vs = 1; s_bl = 0; s_rgb = 0; s_valid = 0;
                o_hs = 1; o_vs = 1; o_bl = 0; o_rgb = 0; o_valid = 0;
                s_h = 0; s_v = 0; s_f = 0;
                o_h = 0; o_v = 0; o_f = 0;
            end else begin
                if (c >= 1 && (c % DIV) == DIV - 1) begin
                    o_hs = s_hs; o_vs = s_vs; o_bl = s_bl;
                    o_rgb = s_rgb; o_valid = s_valid;
                    o_h = s_h; o_v = s_v; o_f = s_f;
                    h   = t % 800;
                    v   = (t / 800) % 525;
                    vis = (h < 640) && (v < 480);
                    s_hs  = !(h >= 656 && h <= 751);
                    s_vs  = !(v >= 490 && v <= 491);
                    s_bl  = vis;
                    s_rgb = vis ? mm[(v / 4) * 160 + h / 4] : 3'b000;
                    s_valid = 1;
                    s_h = h; s_v = v; s_f = t / FRAME;
                    t++;
                end
                if (writeEn && c >= 19200 && int'(x) < 160
                    && int'(y) < 120)
                    mm[int'(y) * 160 + int'(x)] = colour;
                c++;
            end
        end
    end

    // Compare process plus hand-computed pixel expectations.
    initial begin
        logic        e_pix;
        logic [29:0] av, ev;
        logic [23:0] rgb;
        forever begin
            @(negedge clk);
            if (mv) begin
                e_pix = (c >= 1) && ((c % DIV) == DIV - 1);
                av = {busy, pix_en, frame_start, vga_hs, vga_vs,
                      vga_blank_n, vga_r, vga_g, vga_b};
                ev = {1'(c < 19200), e_pix,
                      1'(e_pix && (t % FRAME) == 0),
                      o_hs, o_vs, o_bl,
                      {8{o_rgb[2]}}, {8{o_rgb[1]}}, {8{o_rgb[0]}}};
                chk("scan", {2'b0, av}, {2'b0, ev});
                if (o_valid && epoch == 0) begin
                    rgb = {vga_r, vga_g, vga_b};
                    if (o_f == 1 && o_h >= 20 && o_h <= 23
                        && o_v >= 12 && o_v <= 15)
                        chk("green_block", {8'h0, rgb}, 32'h0000FF00);
                    if (o_f == 1 && ((o_h == 19 && o_v == 12)
                        || (o_h == 24 && o_v == 12)
                        || (o_h == 20 && o_v == 11)
                        || (o_h == 20 && o_v == 16)))
                        chk("green_nbr", {8'h0, rgb}, 32'h0);
                    if (o_f == 1 && o_h == 0 && (o_v == 0 || o_v == 4))
                        chk("oob_write", {8'h0, rgb}, 32'h0);
                    if (o_f == 1 && o_h == 40 && o_v == 40)
                        chk("busy_write", {8'h0, rgb}, 32'h0);
                    if (o_f == 0 && o_h == 40 && o_v == 160)
                        chk("raw_old", {8'h0, rgb}, 32'h000000FF);
                    if (o_f == 0 && o_h == 41 && o_v == 160)
                        chk("raw_next_px", {8'h0, rgb}, 32'h00FFFF00);
                    if (o_f == 1 && o_h == 40 && o_v == 160)
                        chk("raw_new", {8'h0, rgb}, 32'h00FFFF00);
                end
            end
        end
    end

    // Frame timing measured directly on the pins.
    initial begin
        int  ph, pv, cf, lf;
        bit  have_h, have_v, have_fs;
        logic prev_hs, prev_vs;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                ph = 0; pv = 0; cf = 0; lf = 0;
                have_h = 0; have_v = 0; have_fs = 0;
                prev_hs = 1; prev_vs = 1;
            end else begin
                if (prev_hs && !vga_hs) begin
                    if (have_h) chk("line_ticks", ph, 800);
                    ph = 0; have_h = 1; lf++;
                end
                if (!prev_hs && vga_hs && have_h)
                    chk("hsync_width", ph, 96);
                if (prev_vs && !vga_vs) begin
                    pv = 0; have_v = 1;
                end
                if (!prev_vs && vga_vs && have_v)
                    chk("vsync_width", pv, 1600);
                if (frame_start) begin
                    if (have_fs) begin
                        chk("frame_clks", cf, 420000);
                        chk("frame_lines", lf, 525);
                    end
                    cf = 0; lf = 0; have_fs = 1;
                end
                if (pix_en) begin
                    ph++; pv++;
                end
                cf++;
                prev_hs = vga_hs;
                prev_vs = vga_vs;
            end
        end
    end

    task automatic wait_clear(input string nm);
        int n;
        n = 0;
        x = 8'd10; y = 7'd10; colour = 3'b111;
        do begin
            writeEn = (n == 100);
            nxt();
            n++;
        end while (busy !== 1'b0 && n < 25000);
        writeEn = 1'b0;
        chk(nm, n, 19200);
    endtask

    initial begin
        int g;
        reset = 1'b0; writeEn = 1'b0;
        x = '0; y = '0; colour = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {2'b0, busy, pix_en, frame_start, vga_hs,
            vga_vs, vga_blank_n, vga_r, vga_g, vga_b},
            {2'b0, 6'b100110, 24'h0});
        #1 reset = 1'b1;
        wait_clear("busy_clks");

        put(5, 3, 3'b010);
        put(160, 0, 3'b111);
        put(0, 120, 3'b111);
        put(10, 40, 3'b001);

        g = 0;
        while (t != 128040 && g < 200000) begin
            if (t < 128000) rand_drive(60);
            else writeEn = 1'b0;
            nxt();
            g++;
        end
        put(10, 40, 3'b110);

        g = 0;
        while (t < 551200 && g < 500000) begin
            nxt();
            g++;
        end
        g = 0;
        while (t < 580100 && g < 50000) begin
            rand_drive(0);
            nxt();
            g++;
        end
        put(0, 0, 3'b111);

        epoch = 1;
        reset = 1'b0;
        nxt();
        chk("reset_midframe", {2'b0, busy, pix_en, frame_start,
            vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b},
            {2'b0, 6'b100110, 24'h0});
        nxt();
        nxt();
        reset = 1'b1;
        wait_clear("busy_clks_again");

        g = 0;
        while (t < FRAME + 5 && g < 500000) begin
            nxt();
            g++;
        end
        if (g >= 500000) chk("run_timeout", 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
